// File: rtl/aibcr3_scan_chain_ctrl.sv
// AIB column scan-segment controller.
// Routes NSEG scan segments as independent ATPG chains or as one daisy-chained
// JTAG chain with per-segment 1-bit bypass. A counted shift engine with a
// request/busy/done handshake drives the JTAG chain.
module aibcr3_scan_chain_ctrl #(
    parameter int unsigned NSEG = 4,
    parameter int unsigned CW   = 10
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            scan_mode_n_async,
    output logic            mode_n,
    input  logic [NSEG-1:0] cfg_bypass,
    input  logic            atpg_shift_n,
    input  logic [NSEG-1:0] atpg_scan_in,
    output logic [NSEG-1:0] atpg_scan_out,
    input  logic            jtag_si,
    output logic            jtag_so,
    input  logic            shift_req,
    input  logic [CW-1:0]   shift_len,
    output logic            shift_busy,
    output logic            shift_done,
    output logic [CW-1:0]   shift_cnt,
    output logic [NSEG-1:0] seg_scan_in,
    output logic [NSEG-1:0] seg_shift_en,
    input  logic [NSEG-1:0] seg_scan_out
);

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    localparam logic [CW-1:0] CntOne = {{(CW-1){1'b0}}, 1'b1};

    state_e          state_q;
    logic            mode_meta_q;
    logic            mode_req_q;
    logic            mode_q;
    logic [CW-1:0]   len_q;
    logic [CW-1:0]   cnt_q;
    logic [NSEG-1:0] byp_cfg_q;
    logic [NSEG-1:0] byp_q;
    logic            so_q;

    logic [NSEG-1:0] stage_in;
    logic [NSEG-1:0] stage_out;
    logic [NSEG-1:0] byp_next;
    logic            accept;
    logic            mode_load;

    // JTAG chain wiring: each stage is either its segment or its bypass flop.
    for (genvar g = 0; g < NSEG; g++) begin : g_stage
        assign stage_out[g] = byp_cfg_q[g] ? byp_q[g] : seg_scan_out[g];
        assign byp_next[g]  = byp_cfg_q[g] ? stage_in[g] : byp_q[g];
        if (g == 0) begin : g_first
            assign stage_in[g] = jtag_si;
        end else begin : g_rest
            assign stage_in[g] = stage_out[g-1];
        end
    end

    // Requests are only honoured in JTAG mode while idle.
    assign accept = (state_q == StIdle) && shift_req && mode_q;

    // Mode is applied only when the engine will be idle next cycle, so a
    // change never lands inside a shift and takes effect from the first idle cycle.
    assign mode_load = ((state_q == StIdle) && !accept) || (state_q == StDone);

    // Mode synchroniser, mode apply and shift-engine FSM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_meta_q <= 1'b1;
            mode_req_q  <= 1'b1;
            mode_q      <= 1'b1;
            state_q     <= StIdle;
            len_q       <= '0;
            cnt_q       <= '0;
            byp_cfg_q   <= '0;
            byp_q       <= '0;
            so_q        <= 1'b0;
        end else begin
            mode_meta_q <= scan_mode_n_async;
            mode_req_q  <= mode_meta_q;
            if (mode_load) begin
                mode_q <= mode_req_q;
            end
            unique case (state_q)
                StIdle: begin
                    if (accept) begin
                        cnt_q <= '0;
                        if (shift_len != '0) begin
                            len_q     <= shift_len;
                            byp_cfg_q <= cfg_bypass;
                            state_q   <= StBusy;
                        end else begin
                            state_q <= StDone;
                        end
                    end
                end
                StBusy: begin
                    byp_q <= byp_next;
                    so_q  <= stage_out[NSEG-1];
                    cnt_q <= cnt_q + CntOne;
                    if (cnt_q + CntOne == len_q) begin
                        state_q <= StDone;
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    // Output routing: ATPG passthrough or JTAG chain with gated shift enables.
    always_comb begin
        atpg_scan_out = '0;
        seg_scan_in   = stage_in;
        seg_shift_en  = '0;
        if (mode_q) begin
            if (state_q == StBusy) begin
                seg_shift_en = ~byp_cfg_q;
            end
        end else begin
            atpg_scan_out = seg_scan_out;
            seg_scan_in   = atpg_scan_in;
            seg_shift_en  = {NSEG{~atpg_shift_n}};
        end
    end

    assign mode_n     = mode_q;
    assign jtag_so    = so_q;
    assign shift_busy = (state_q == StBusy);
    assign shift_done = (state_q == StDone);
    assign shift_cnt  = cnt_q;

endmodule
